// File: rtl/unidad_control.sv
// Control unit: fetches an 8-bit instruction, decodes it into the datapath control word
// during a single execute cycle, and sequences pc through jumps, branches and HALT.
module unidad_control #(
    parameter logic [3:0]  ALU_ADD  = 4'b0000,
    parameter logic [3:0]  ALU_SUB  = 4'b0001,
    parameter logic [3:0]  ALU_AND  = 4'b0010,
    parameter logic [3:0]  ALU_OR   = 4'b0011,
    parameter logic [3:0]  ALU_XOR  = 4'b0100,
    parameter logic [1:0]  SH_NONE  = 2'b00,
    parameter logic [1:0]  SH_LEFT  = 2'b01,
    parameter logic [1:0]  SH_RIGHT = 2'b10,
    parameter int unsigned FLAG_Z   = 0,
    parameter int unsigned FLAG_C   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  instr,
    input  logic [3:0]  flags,
    output logic [3:0]  pc,
    output logic [15:0] control,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_r, state_s;
    logic [3:0]  pc_r, pc_s;
    logic [15:0] control_r, control_s;
    logic [7:0]  ir_r, ir_s;
    logic        busy_r, halted_r;
    logic        unused_flags_s;

    // Word layout: {regA, regB, dest, we, MB, ALU, SH, MF, MD}
    function automatic logic [15:0] decode(input logic [7:0] ins);
        logic [1:0] a;
        logic [1:0] b;
        a = ins[3:2];
        b = ins[1:0];
        case (ins[7:4])
            4'h1:    decode = {2'b00, 2'b00, a, 1'b1, 1'b0, 4'b0000, SH_NONE,  1'b0, 1'b1};
            4'h2:    decode = {2'b00, b,     a, 1'b1, 1'b0, 4'b0000, SH_NONE,  1'b1, 1'b0};
            4'h3:    decode = {a,     b,     a, 1'b1, 1'b0, ALU_ADD, SH_NONE,  1'b0, 1'b0};
            4'h4:    decode = {a,     b,     a, 1'b1, 1'b0, ALU_SUB, SH_NONE,  1'b0, 1'b0};
            4'h5:    decode = {a,     b,     a, 1'b1, 1'b0, ALU_AND, SH_NONE,  1'b0, 1'b0};
            4'h6:    decode = {a,     b,     a, 1'b1, 1'b0, ALU_OR,  SH_NONE,  1'b0, 1'b0};
            4'h7:    decode = {a,     b,     a, 1'b1, 1'b0, ALU_XOR, SH_NONE,  1'b0, 1'b0};
            4'h8:    decode = {2'b00, b,     a, 1'b1, 1'b0, 4'b0000, SH_LEFT,  1'b1, 1'b0};
            4'h9:    decode = {2'b00, b,     a, 1'b1, 1'b0, 4'b0000, SH_RIGHT, 1'b1, 1'b0};
            4'hA:    decode = {2'b00, a, 12'b0001_0000_0000};
            default: decode = 16'h0000;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] fl);
        case (op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JZ:   branch_taken = fl[FLAG_Z];
            OP_JNZ:  branch_taken = ~fl[FLAG_Z];
            OP_JC:   branch_taken = fl[FLAG_C];
            default: branch_taken = 1'b0;
        endcase
    endfunction

    assign unused_flags_s = ^flags;

    // Next-state, pc sequencing and control-word generation
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        control_s = 16'h0000;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_s = ST_FETCH;
                    pc_s    = 4'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s   = ST_EXEC;
                ir_s      = instr;
                control_s = decode(instr);
            end
            ST_EXEC: begin
                if (ir_r[7:4] == OP_HALT) begin
                    state_s = ST_HALT;
                end else if (branch_taken(ir_r[7:4], flags)) begin
                    state_s = ST_FETCH;
                    pc_s    = ir_r[3:0];
                end else begin
                    state_s = ST_FETCH;
                    pc_s    = pc_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = 4'd0;
            end
        endcase
    end

    // State, pc, instruction and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= 4'd0;
            ir_r      <= 8'h00;
            control_r <= 16'h0000;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            control_r <= control_s;
            busy_r    <= (state_s == ST_FETCH) || (state_s == ST_EXEC);
            halted_r  <= (state_s == ST_HALT);
        end
    end

    assign pc      = pc_r;
    assign control = control_r;
    assign busy    = busy_r;
    assign halted  = halted_r;

endmodule
